// File: rtl/ysyx_040066_clint_mh_if.sv
// Data-memory bus between the CPU load/store unit and the CLINT.
// The CLINT claims its own region and forwards all other requests as MemRd_real/MemWr_real.
interface ysyx_040066_clint_mh_if;
    logic [63:0] addr;
    logic        MemRd;
    logic        MemWr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        MemRd_real;
    logic        MemWr_real;
    logic [63:0] rdata;
    logic        rvalid;
    logic        error;

    modport master (
        output addr, MemRd, MemWr, wdata, wmask,
        input  MemRd_real, MemWr_real, rdata, rvalid, error
    );

    modport slave (
        input  addr, MemRd, MemWr, wdata, wmask,
        output MemRd_real, MemWr_real, rdata, rvalid, error
    );
endinterface

// File: rtl/ysyx_040066_clint_mh.sv
// Multi-hart CLINT: shared prescaled 64-bit mtime, per-hart mtimecmp/msip, byte-masked writes.
// Define YSYX_040066_CLINT_STOP_EN to add a time_stop input that freezes mtime and the prescaler.
module ysyx_040066_clint_mh #(
    parameter int unsigned NHART        = 1,
    parameter logic [63:0] BASE         = 64'h0200_0000,
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef YSYX_040066_CLINT_STOP_EN
    input  logic                 time_stop,
`endif
    ysyx_040066_clint_mh_if.slave bus,
    output logic [NHART-1:0]     mtip,
    output logic [NHART-1:0]     msip
);

    localparam logic [15:0] OFF_MTIME = 16'hBFF8;

    logic [63:0]      r_mtime;
    logic [31:0]      r_presc;
    logic [63:0]      r_mtimecmp [NHART];
    logic [NHART-1:0] r_msip;
    logic [63:0]      r_rdata;
    logic             r_rvalid;
    logic             r_error;

    logic [15:0]      w_off;
    logic             w_hit;
    logic             w_is_msip;
    logic             w_is_cmp;
    logic             w_is_mtime;
    logic             w_legal;
    logic [3:0]       w_idx;
    logic             w_wr;
    logic             w_stop;
    logic             w_tick;
    logic [63:0]      w_mtime_d;
    logic [31:0]      w_presc_d;
    logic [63:0]      w_cmp_d [NHART];
    logic [NHART-1:0] w_msip_d;
    logic [63:0]      w_rdata_d;

    function automatic logic [63:0] f_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                            input logic [7:0] mask);
        logic [63:0] v;
        v = old_v;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) v[8*b +: 8] = new_v[8*b +: 8];
        end
        return v;
    endfunction

    // BASE is 64 KiB aligned, so the upper address bits select the region and the low 16 are the offset.
    assign w_off      = bus.addr[15:0];
    assign w_hit      = (bus.addr[63:16] == BASE[63:16]) && (w_off < 16'hC000);
    assign w_is_msip  = w_hit && (32'(w_off[15:2]) < NHART) && (w_off[1:0] == 2'b00);
    assign w_is_cmp   = w_hit && (w_off[15:14] == 2'b01) && (32'(w_off[13:3]) < NHART)
                        && (w_off[2:0] == 3'b000);
    assign w_is_mtime = w_hit && (w_off == OFF_MTIME);
    assign w_legal    = w_is_msip || w_is_cmp || w_is_mtime;
    assign w_idx      = w_is_msip ? w_off[5:2] : w_off[6:3];
    assign w_wr       = bus.MemWr && w_legal;

`ifdef YSYX_040066_CLINT_STOP_EN
    assign w_stop = time_stop;
`else
    assign w_stop = 1'b0;
`endif

    assign w_tick = !w_stop && (r_presc == TICK_DIV - 1);

    always_comb begin
        w_presc_d = r_presc;
        if (!w_stop) w_presc_d = (r_presc == TICK_DIV - 1) ? 32'd0 : r_presc + 32'd1;

        // A software write to mtime overrides the tick increment of the same cycle.
        w_mtime_d = r_mtime;
        if (w_tick) w_mtime_d = r_mtime + 64'd1;
        if (w_wr && w_is_mtime) w_mtime_d = f_merge(r_mtime, bus.wdata, bus.wmask);

        w_msip_d  = r_msip;
        w_rdata_d = '0;
        for (int h = 0; h < NHART; h++) begin
            w_cmp_d[h] = r_mtimecmp[h];
            if (w_idx == 4'(h)) begin
                if (w_wr && w_is_cmp) w_cmp_d[h] = f_merge(r_mtimecmp[h], bus.wdata, bus.wmask);
                if (w_wr && w_is_msip) begin
                    if (bus.addr[2]) begin
                        if (bus.wmask[4]) w_msip_d[h] = bus.wdata[32];
                    end else if (bus.wmask[0]) begin
                        w_msip_d[h] = bus.wdata[0];
                    end
                end
                if (w_is_cmp) w_rdata_d = r_mtimecmp[h];
                if (w_is_msip) begin
                    if (bus.addr[2]) w_rdata_d[32] = r_msip[h];
                    else             w_rdata_d[0]  = r_msip[h];
                end
            end
        end
        if (w_is_mtime) w_rdata_d = r_mtime;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime  <= '0;
            r_presc  <= '0;
            for (int h = 0; h < NHART; h++) r_mtimecmp[h] <= MTIMECMP_RST;
            r_msip   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_mtime  <= w_mtime_d;
            r_presc  <= w_presc_d;
            for (int h = 0; h < NHART; h++) r_mtimecmp[h] <= w_cmp_d[h];
            r_msip   <= w_msip_d;
            r_rvalid <= bus.MemRd && w_hit;
            r_error  <= (bus.MemRd || bus.MemWr) && w_hit && !w_legal;
            if (bus.MemRd && w_hit) r_rdata <= w_rdata_d;
        end
    end

    always_comb begin
        mtip = '0;
        for (int h = 0; h < NHART; h++) mtip[h] = (r_mtime >= r_mtimecmp[h]);
    end

    assign msip           = r_msip;
    assign bus.MemRd_real = bus.MemRd && !w_hit;
    assign bus.MemWr_real = bus.MemWr && !w_hit;
    assign bus.rdata      = r_rdata;
    assign bus.rvalid     = r_rvalid;
    assign bus.error      = r_error;

endmodule

// File: doc/ysyx_040066_clint_mh.md
Name: ysyx_040066_clint_mh

Overview:
Parametrised multi-hart core-local interruptor: one shared 64-bit mtime with programmable prescaler, per-hart mtimecmp and msip. Sits on the CPU data-memory path and claims accesses in [BASE, BASE+0xC000); all other accesses pass through to memory. Generates per-hart mtip/msip. Adds byte-masked writes, prescaling and out-of-map error reporting.

Parameters:
NHART, 1, number of harts (1..16)
BASE, 64'h0200_0000, region base address, 64 KiB-aligned
TICK_DIV, 1, mtime increments once every TICK_DIV clocks (>=1)
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every mtimecmp

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
addr  in  64  byte address
MemRd  in  1  read request
MemWr  in  1  write request
wdata  in  64  write data, lane-aligned to addr[2:0]
wmask  in  8  byte enables
MemRd_real  out  1  MemRd && !hit (combinational)
MemWr_real  out  1  MemWr && !hit (combinational)
rdata  out  64  read data, registered
rvalid  out  1  registered: previous cycle was a claimed read
error  out  1  registered: previous cycle was a bad claimed access
mtip  out  NHART  timer interrupt per hart
msip  out  NHART  software interrupt per hart

Behaviour:
- hit = addr in [BASE, BASE+0xC000). off = addr-BASE (16 bit).
- Map: msip[h] at off 4*h (32-bit, bit0 only, rest RAZ/WI); mtimecmp[h] at 0x4000+8*h; mtime at 0xBFF8.
- Legal access: hit, matches a mapped register, msip needs addr[1:0]==0, 64-bit regs need addr[2:0]==0. Anything else hit -> bad.
- Reset (async, rst_n=0): mtime=0, prescaler=0, mtimecmp[*]=MTIMECMP_RST, msip[*]=0, rdata=0, rvalid=0, error=0. Release is synchronous to clk edge use; no access taken during reset.
- Prescaler: counts 0..TICK_DIV-1; mtime+=1 on cycle counter==TICK_DIV-1, counter wraps to 0. TICK_DIV=1 -> increment every cycle. mtime wraps 2^64-1 -> 0 silently.
- Writes (MemWr && legal): byte-merge with wmask; msip uses lane addr[2] (byte 0 or byte 4), only bit0 of that byte stored. Write to mtime in same cycle as tick: written value wins, no increment; prescaler not reset. Bad write: no state change, error=1 next cycle.
- Reads (MemRd && hit): rdata next cycle; msip value placed at bit 0 or bit 32 per addr[2], other bits 0; bad read returns 0 with error=1. rvalid=1 next cycle for any claimed read.
- Read during write same cycle (MemRd&&MemWr): write applied, rdata returns pre-write value.
- mtip[h] = (mtime >= mtimecmp[h]) combinational from registers (unsigned). msip[h] = stored bit.
- MemRd_real/MemWr_real never asserted for hit addresses; no latency added to pass-through.
- error and rvalid are single-cycle pulses per access.

Optional Feature:
YSYX_040066_CLINT_STOP_EN: adds input port time_stop (1 bit). When defined and time_stop=1, prescaler and mtime hold (software writes still take effect). When undefined, port absent and mtime always runs.

Test Plan:
- Reset, NHART=2, TICK_DIV=1: mtime reads 0 -> counts; mtimecmp[1] read at BASE+0x4008 -> FFFF_FFFF_FFFF_FFFF, mtip=2'b00.
- Write mtimecmp[0]=0x20, mtime=0x10 -> mtip[0] rises exactly when mtime reaches 0x20; writing mtimecmp[0]=~0 clears it next cycle.
- TICK_DIV=4: mtime advances 1 per 4 clocks; write mtime=5 on a tick cycle -> reads 5, not 6.
- Write BASE+0x4 wdata[32]=1 wmask=8'h10 -> msip=2'b10; read BASE+0x4 -> rdata=0x1_0000_0000, rvalid=1.
- Masked write wmask=8'h0F data 0xAAAA_BBBB to mtimecmp[0]=0 -> 0x0000_0000_AAAA_BBBB... upper bytes unchanged (0).
- Read BASE+0x8000 and BASE+0x4004 -> error=1, rdata=0, no state change; read 0x8000_0000 -> MemRd_real=1, rvalid=0.
